// File: rtl/pp_fifo2axis_tx_pkg.sv
// Shared definitions for the FIFO-to-AXI4-Stream frame transmitter.
package pp_fifo2axis_tx_pkg;

  localparam int unsigned DIM_WIDTH_DEF  = 12;
  localparam int unsigned DATA_WIDTH_DEF = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/pp_fifo2axis_tx_pos.sv
// Frame position tracker: column/row counters plus first-pixel,
// end-of-row and end-of-frame decodes for the pixel about to be read.
module pp_fifo2axis_tx_pos
  import pp_fifo2axis_tx_pkg::*;
#(
  parameter int unsigned DIM_WIDTH = DIM_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [DIM_WIDTH-1:0] cfg_cols,
  input  logic [DIM_WIDTH-1:0] cfg_rows,
  input  logic                 advance,
  output logic                 first_c,
  output logic                 last_col_c,
  output logic                 last_pix_c
);

  logic [DIM_WIDTH-1:0] cols_q;
  logic [DIM_WIDTH-1:0] rows_q;
  logic [DIM_WIDTH-1:0] col_cnt;
  logic [DIM_WIDTH-1:0] row_cnt;

  // Frame size is captured once per frame; counters walk raster order.
  always_ff @(posedge clk) begin
    if (reset) begin
      cols_q  <= '0;
      rows_q  <= '0;
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (load) begin
      cols_q  <= cfg_cols;
      rows_q  <= cfg_rows;
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (advance) begin
      if (last_col_c) begin
        col_cnt <= '0;
        row_cnt <= row_cnt + DIM_WIDTH'(1);
      end else begin
        col_cnt <= col_cnt + DIM_WIDTH'(1);
      end
    end
  end

  assign first_c    = (col_cnt == '0) && (row_cnt == '0);
  assign last_col_c = (col_cnt == cols_q - DIM_WIDTH'(1));
  assign last_pix_c = last_col_c && (row_cnt == rows_q - DIM_WIDTH'(1));

endmodule

// File: rtl/pp_fifo2axis_tx.sv
// Reads a cols x rows frame from a show-ahead FIFO and emits it as an
// AXI4-Stream (tuser = start of frame, tlast = end of row) at 1 pixel/clk.
module pp_fifo2axis_tx
  import pp_fifo2axis_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned DIM_WIDTH  = DIM_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DIM_WIDTH-1:0]  cfg_cols,
  input  logic [DIM_WIDTH-1:0]  cfg_rows,
  input  logic                  fifo_empty_n,
  output logic                  fifo_read,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  busy,
  output logic                  done
);

  state_t state;
  state_t next_state;
  logic   load_c;
  logic   done_c;
  logic   out_free_c;
  logic   cfg_zero_c;
  logic   first_c;
  logic   last_col_c;
  logic   last_pix_c;

  assign out_free_c = ~m_axis_tvalid | m_axis_tready;
  assign cfg_zero_c = (cfg_cols == '0) || (cfg_rows == '0);
  assign fifo_read  = ~reset & (state == RUN) & fifo_empty_n & out_free_c;

  pp_fifo2axis_tx_pos #(
    .DIM_WIDTH (DIM_WIDTH)
  ) u_pos (
    .clk        (clk),
    .reset      (reset),
    .load       (load_c),
    .cfg_cols   (cfg_cols),
    .cfg_rows   (cfg_rows),
    .advance    (fifo_read),
    .first_c    (first_c),
    .last_col_c (last_col_c),
    .last_pix_c (last_pix_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state != IDLE);
      done  <= done_c;
    end
  end

  // A zero-sized frame completes immediately without leaving IDLE.
  always_comb begin
    next_state = state;
    load_c     = 1'b0;
    done_c     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (cfg_zero_c) begin
            done_c = 1'b1;
          end else begin
            load_c     = 1'b1;
            next_state = RUN;
          end
        end
      end
      RUN: begin
        if (fifo_read && last_pix_c) begin
          next_state = FLUSH;
        end
      end
      FLUSH: begin
        if (m_axis_tvalid && m_axis_tready) begin
          next_state = IDLE;
          done_c     = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Single-entry output stage; a read refills it in the same cycle it drains.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
    end else if (fifo_read) begin
      m_axis_tdata  <= fifo_dout;
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= last_col_c;
      m_axis_tuser  <= first_c;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pp_fifo2axis_tx.sv
// Bench for pp_fifo2axis_tx: a queue-based FIFO model and an expected-beat
// list derived from frame size, plus hand sequences for reset and empty frames.
module tb_pp_fifo2axis_tx;

  localparam int unsigned DW = 24;
  localparam int unsigned MW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [MW-1:0] cfg_cols;
  logic [MW-1:0] cfg_rows;
  logic          fifo_empty_n;
  logic          fifo_read;
  logic [DW-1:0] fifo_dout;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          m_axis_tuser;
  logic          busy;
  logic          done;

  pp_fifo2axis_tx #(.DATA_WIDTH(DW), .DIM_WIDTH(MW)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .cfg_cols      (cfg_cols),
    .cfg_rows      (cfg_rows),
    .fifo_empty_n  (fifo_empty_n),
    .fifo_read     (fifo_read),
    .fifo_dout     (fifo_dout),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cols;
    int rows;
    int gate;        // 0 always data, 1 every other cycle, 2 random
    int ready;       // 0 always, 1 random, 2 five-cycle stall after beat 0
    int restart_at;  // cycle at which a stray start is pulsed, -1 none
    int exp_first;   // cycle of beat 0 with back-to-back beats, -1 don't care
    int exp_last;    // cycle of final beat, -1 don't care
  } frame_vec_t;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];
  logic          gate_en;

  logic          s_rd, s_valid, s_ready, s_last, s_user, s_done, s_busy, s_en;
  logic [DW-1:0] s_data;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: drive FIFO head, sample mid-cycle, pop on the edge.
  task automatic do_cycle();
    fifo_empty_n = gate_en && (fq.size() > 0);
    fifo_dout    = (fq.size() > 0) ? fq[0] : '0;
    #1;
    s_rd    = fifo_read;
    s_en    = fifo_empty_n;
    s_valid = m_axis_tvalid;
    s_ready = m_axis_tready;
    s_data  = m_axis_tdata;
    s_last  = m_axis_tlast;
    s_user  = m_axis_tuser;
    s_done  = done;
    s_busy  = busy;
    @(posedge clk);
    if (s_rd && fq.size() > 0) void'(fq.pop_front());
    @(negedge clk);
  endtask

  task automatic run_frame(input frame_vec_t v);
    int total, beats, final_cyc, stall_left;
    logic          p_valid, p_ready, p_last, p_user;
    logic [DW-1:0] p_data;
    total = v.cols * v.rows;
    fq.delete();
    exp_q.delete();
    for (int i = 0; i < total + 3; i++) begin
      logic [DW-1:0] d;
      d = DW'($urandom);
      fq.push_back(d);
      if (i < total) exp_q.push_back(d);
    end
    beats = 0; final_cyc = -1; stall_left = 0;
    p_valid = 1'b0; p_ready = 1'b0; p_last = 1'b0; p_user = 1'b0; p_data = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      start = (cyc == 0) || (cyc == v.restart_at);
      if (cyc == 0) begin
        cfg_cols = MW'(v.cols);
        cfg_rows = MW'(v.rows);
      end else begin
        cfg_cols = MW'(1);
        cfg_rows = MW'(1);
      end
      case (v.gate)
        0:       gate_en = 1'b1;
        1:       gate_en = (cyc % 2 == 1);
        default: gate_en = ($urandom_range(0, 3) != 0);
      endcase
      case (v.ready)
        0: m_axis_tready = 1'b1;
        1: m_axis_tready = 1'($urandom_range(0, 1));
        default: begin
          m_axis_tready = (stall_left == 0);
          if (stall_left > 0) stall_left--;
        end
      endcase
      do_cycle();
      if (s_rd) chk("read_needs_data", s_en, 1);
      if (s_valid && !s_ready) chk("read_while_stalled", s_rd, 0);
      if (p_valid && !p_ready) begin
        chk("hold_valid", s_valid, 1);
        chk("hold_data", s_data, p_data);
        chk("hold_last", s_last, p_last);
        chk("hold_user", s_user, p_user);
      end
      if (s_valid && s_ready) begin
        if (beats < total) begin
          chk("beat_data", s_data, exp_q[beats]);
          chk("beat_last", s_last, (beats % v.cols) == v.cols - 1);
          chk("beat_user", s_user, beats == 0);
          if (v.exp_first >= 0) chk("beat_cycle", cyc, v.exp_first + beats);
          beats++;
          if (beats == total) final_cyc = cyc;
          if (v.ready == 2 && beats == 1) stall_left = 5;
        end else begin
          chk("extra_beat", beats + 1, total);
        end
      end
      chk("done", s_done, (final_cyc >= 0) && (cyc == final_cyc + 1));
      if (cyc >= 1 && (final_cyc < 0 || cyc <= final_cyc)) chk("busy_run", s_busy, 1);
      if (final_cyc >= 0 && cyc == final_cyc + 1) chk("busy_idle", s_busy, 0);
      p_valid = s_valid; p_ready = s_ready; p_data = s_data;
      p_last = s_last; p_user = s_user;
      if (final_cyc >= 0 && cyc == final_cyc + 2) break;
    end
    start = 1'b0;
    chk("beat_count", beats, total);
    chk("fifo_left", fq.size(), 3);
    if (v.exp_last >= 0) chk("last_beat_cycle", final_cyc, v.exp_last);
  endtask

  initial begin
    frame_vec_t vecs[5];
    frame_vec_t rv;
    int hs;

    vecs[0] = '{cols: 4, rows: 2, gate: 0, ready: 0, restart_at: -1, exp_first: 2,  exp_last: 9};
    vecs[1] = '{cols: 3, rows: 1, gate: 0, ready: 2, restart_at: -1, exp_first: -1, exp_last: 9};
    vecs[2] = '{cols: 5, rows: 3, gate: 1, ready: 0, restart_at: -1, exp_first: -1, exp_last: -1};
    vecs[3] = '{cols: 4, rows: 3, gate: 0, ready: 0, restart_at: 5,  exp_first: 2,  exp_last: 13};
    vecs[4] = '{cols: 3, rows: 2, gate: 2, ready: 1, restart_at: -1, exp_first: -1, exp_last: -1};

    reset = 1'b1; start = 1'b0; cfg_cols = '0; cfg_rows = '0;
    gate_en = 1'b1; fifo_empty_n = 1'b0; fifo_dout = '0; m_axis_tready = 1'b1;
    fq.delete();
    fq.push_back(DW'(24'h123456));
    @(negedge clk);
    do_cycle();
    do_cycle();
    chk("rst_tvalid", s_valid, 0);
    chk("rst_tlast", s_last, 0);
    chk("rst_tuser", s_user, 0);
    chk("rst_tdata", s_data, 0);
    chk("rst_done", s_done, 0);
    chk("rst_busy", s_busy, 0);
    chk("rst_read", s_rd, 0);
    reset = 1'b0;
    do_cycle();

    foreach (vecs[i]) run_frame(vecs[i]);

    // Zero-sized frames: immediate done, no reads, stay idle.
    for (int z = 0; z < 2; z++) begin
      fq.delete();
      fq.push_back(DW'(24'hABCDEF));
      fq.push_back(DW'(24'h000001));
      gate_en = 1'b1;
      start = 1'b1;
      cfg_cols = (z == 0) ? MW'(0) : MW'(3);
      cfg_rows = (z == 0) ? MW'(3) : MW'(0);
      do_cycle();
      chk("zero_no_read0", s_rd, 0);
      start = 1'b0;
      do_cycle();
      chk("zero_done", s_done, 1);
      chk("zero_no_read1", s_rd, 0);
      chk("zero_busy", s_busy, 0);
      do_cycle();
      chk("zero_done_clear", s_done, 0);
      chk("zero_fifo_left", fq.size(), 2);
    end

    // Reset after five beats of a 4x4 frame abandons it silently.
    fq.delete();
    for (int i = 0; i < 20; i++) fq.push_back(DW'(i + 1));
    gate_en = 1'b1; m_axis_tready = 1'b1;
    start = 1'b1; cfg_cols = MW'(4); cfg_rows = MW'(4);
    hs = 0;
    for (int c = 0; c < 50 && hs < 5; c++) begin
      do_cycle();
      start = 1'b0;
      if (s_valid && s_ready) hs++;
    end
    chk("pre_reset_beats", hs, 5);
    reset = 1'b1;
    do_cycle();
    chk("reset_read_low", s_rd, 0);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      do_cycle();
      chk("post_reset_tvalid", s_valid, 0);
      chk("post_reset_done", s_done, 0);
      chk("post_reset_busy", s_busy, 0);
      chk("post_reset_read", s_rd, 0);
    end
    rv = '{cols: 2, rows: 2, gate: 0, ready: 0, restart_at: -1, exp_first: 2, exp_last: 5};
    run_frame(rv);

    // Randomized frames against the raster-order model.
    for (int r = 0; r < 6; r++) begin
      rv.cols = $urandom_range(1, 5);
      rv.rows = $urandom_range(1, 4);
      rv.gate = $urandom_range(0, 2);
      rv.ready = $urandom_range(0, 1);
      rv.restart_at = (r % 2 == 0) ? 3 : -1;
      rv.exp_first = -1;
      rv.exp_last = -1;
      run_frame(rv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pp_fifo2axis_tx.md
PP_FIFO2AXIS_TX -- requirements
Module: pp_fifo2axis_tx

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 24, giving the pixel width of the FIFO and stream data.
REQ-002 The block SHALL have parameter DIM_WIDTH, default 12, giving the width of the row and column counts.
REQ-003 The block SHALL have port clk, input, 1 bit, the system clock; all logic is on the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit, a one-cycle frame-start request, accepted only in IDLE.
REQ-006 The block SHALL have ports cfg_cols and cfg_rows, input, DIM_WIDTH bits each, giving the frame size, sampled when start is accepted.
REQ-007 The block SHALL have port fifo_empty_n, input, 1 bit; high means the FIFO head word is valid.
REQ-008 The block SHALL have port fifo_read, output, 1 bit, which pops the FIFO head in the same cycle.
REQ-009 The block SHALL have port fifo_dout, input, DATA_WIDTH bits, the FIFO head word, valid while fifo_empty_n is high.
REQ-010 The block SHALL have ports m_axis_tdata (output, DATA_WIDTH bits), m_axis_tvalid (output, 1 bit), m_axis_tready (input, 1 bit), m_axis_tlast (output, 1 bit, end of row) and m_axis_tuser (output, 1 bit, start of frame), forming an AXI4-Stream master.
REQ-011 The block SHALL have port busy, output, 1 bit, high in any state other than IDLE.
REQ-012 The block SHALL have port done, output, 1 bit, a one-cycle pulse when a frame completes.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and FLUSH.
REQ-014 In IDLE with start high, the block SHALL latch cfg_cols and cfg_rows, clear col_cnt and row_cnt, and go to RUN.
REQ-015 In IDLE with start high and cfg_cols==0 or cfg_rows==0, the block SHALL pulse done on the next cycle, perform no FIFO reads, and stay in IDLE.
REQ-016 The output stage SHALL be a single register: out_free = ~m_axis_tvalid | m_axis_tready.
REQ-017 fifo_read SHALL equal (state==RUN) & fifo_empty_n & out_free, and is combinational.
REQ-018 On fifo_read, the block SHALL load fifo_dout into m_axis_tdata and set m_axis_tvalid on the next edge.
REQ-019 When m_axis_tready is high and no fifo_read occurs, m_axis_tvalid SHALL clear.
REQ-020 When a fifo_read and an output handshake occur in the same cycle, the block SHALL reload m_axis_tdata with no bubble, giving a sustained throughput of 1 pixel/clk.
REQ-021 m_axis_tdata, m_axis_tlast and m_axis_tuser SHALL hold stable while m_axis_tvalid is high and m_axis_tready is low.
REQ-022 Each fifo_read SHALL advance col_cnt; when col_cnt reaches cols-1 it SHALL wrap to 0 and increment row_cnt.
REQ-023 The registered m_axis_tlast SHALL be set when col_cnt==cols-1 at read time.
REQ-024 The registered m_axis_tuser SHALL be set when col_cnt==0 and row_cnt==0 at read time.
REQ-025 A read with col_cnt==cols-1 and row_cnt==rows-1 SHALL move the FSM from RUN to FLUSH, and no further reads SHALL occur.
REQ-026 In FLUSH, the block SHALL go to IDLE and pulse done in the cycle after the final beat handshake (m_axis_tvalid & m_axis_tready).
REQ-027 start SHALL be ignored outside IDLE.
REQ-028 fifo_empty_n low in RUN SHALL stall the block with no state change.
REQ-029 The block SHALL issue no read when fifo_empty_n is low.
REQ-030 The latency from fifo_read to m_axis_tvalid SHALL be exactly 1 clk.

Reset
REQ-031 Reset SHALL take priority over all other inputs.
REQ-032 Reset SHALL return the FSM to IDLE.
REQ-033 Reset SHALL clear m_axis_tvalid, m_axis_tlast, m_axis_tuser, done, busy, col_cnt and row_cnt to 0, and drive fifo_read to 0 combinationally.
REQ-034 Reset mid-frame SHALL abandon the frame without a done pulse, leaving unread FIFO data untouched.
REQ-035 m_axis_tdata SHALL reset to 0.

Structure
REQ-036 A shared package SHALL hold the FSM state encoding (IDLE=0, RUN=1, FLUSH=2, 2 bits) and the DIM_WIDTH default constant.
REQ-037 One sub-module, pp_fifo2axis_tx_pos, SHALL hold the col/row counters and the tlast/tuser/last-pixel decode.
REQ-038 The top level SHALL hold the FSM and the output register.

Verification
REQ-039 A bench SHALL check: 4x2 frame, FIFO always non-empty, tready=1 -> 8 beats on consecutive cycles; tuser on beat 0 only; tlast on beats 3 and 7; done 1 clk after beat 7.
REQ-040 A bench SHALL check: 3x1 frame, tready low for 5 cycles after the first beat -> tdata, tuser and tvalid stay stable; fifo_read stays low; 3 beats total and no lost data.
REQ-041 A bench SHALL check: FIFO empty_n toggling every other cycle -> beats arrive gapped, data order is preserved, and the total equals cols*rows.
REQ-042 A bench SHALL check: start with cfg_cols=0 -> no fifo_read and a done pulse in the next cycle.
REQ-043 A bench SHALL check: reset asserted after 5 of 16 beats -> tvalid is 0 next cycle, no done pulse, and a following start of a 2x2 frame yields tuser on its first beat.
REQ-044 A bench SHALL check: start pulsed in RUN -> ignored, and the frame completes with its original size.
